// File: rtl/mc_proc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mc_proc_pkg : opcodes, R-type function codes and FSM states shared   |
// |               by the multi-cycle core and its register file.         |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package mc_proc_pkg;

    localparam int REG_CNT = 8;

    localparam logic [4:0] OP_HALT  = 5'b00000;
    localparam logic [4:0] OP_NOP   = 5'b00001;
    localparam logic [4:0] OP_ADDI  = 5'b01000;
    localparam logic [4:0] OP_XORI  = 5'b01010;
    localparam logic [4:0] OP_RTYPE = 5'b11011;
    localparam logic [4:0] OP_ST    = 5'b10000;
    localparam logic [4:0] OP_LD    = 5'b10001;
    localparam logic [4:0] OP_BEQZ  = 5'b01100;
    localparam logic [4:0] OP_BNEZ  = 5'b01101;

    localparam logic [1:0] FN_ADD  = 2'b00;
    localparam logic [1:0] FN_SUB  = 2'b01;
    localparam logic [1:0] FN_XOR  = 2'b10;
    localparam logic [1:0] FN_ANDN = 2'b11;

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        EXEC  = 3'd1,
        MEM   = 3'd2,
        WB    = 3'd3,
        HALT  = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/mc_proc_rf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mc_proc_rf : 8 x DATA_W register file, two combinational read ports, |
// |              one synchronous write port, async reset to zero.        |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module mc_proc_rf
    import mc_proc_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [2:0]        i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [2:0]        i_raddr_a,
    input  logic [2:0]        i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b
);

    logic [DATA_W-1:0] regs_q [REG_CNT];
    logic [DATA_W-1:0] regs_d [REG_CNT];

    always_comb begin
        regs_d = regs_q;
        if (i_we) begin
            regs_d[i_waddr] = i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_CNT; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign o_rdata_a = regs_q[i_raddr_a];
    assign o_rdata_b = regs_q[i_raddr_b];

endmodule
`default_nettype wire

// File: rtl/mc_proc_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mc_proc_core : multi-cycle core, FETCH/EXEC/MEM/WB FSM with req/rdy  |
// |                memory handshakes. Macro PERF_CNT_EN adds the         |
// |                retired-instruction counter.                          |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module mc_proc_core
    import mc_proc_pkg::*;
#(
    parameter int              DATA_W   = 16,
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_rdy,
    input  logic [15:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_rdy,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              halted,
    output logic              err,
    output logic [31:0]       retired_cnt
);

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              halted_q, halted_d;
    logic              err_q, err_d;

    logic [4:0]        w_op;
    logic [2:0]        w_rd;
    logic              w_rf_we;
    logic [DATA_W-1:0] w_rs_val, w_rt_val, w_imm_s, w_imm_z, w_alu;
    logic [PC_W-1:0]   w_pc_inc, w_pc_br;

    assign w_op     = ir_q[15:11];
    assign w_rd     = (w_op == OP_RTYPE) ? ir_q[4:2] : ir_q[7:5];
    assign w_imm_s  = {{(DATA_W-5){ir_q[4]}}, ir_q[4:0]};
    assign w_imm_z  = {{(DATA_W-5){1'b0}}, ir_q[4:0]};
    assign w_pc_inc = pc_q + PC_W'(2);
    assign w_pc_br  = w_pc_inc + {{(PC_W-9){ir_q[7]}}, ir_q[7:0], 1'b0};
    // Stores also pass through WB, but only to advance the PC.
    assign w_rf_we  = (state_q == WB) && (w_op != OP_ST);

    mc_proc_rf #(.DATA_W(DATA_W)) u_rf (
        .clk       (clk),
        .rst       (rst),
        .i_we      (w_rf_we),
        .i_waddr   (w_rd),
        .i_wdata   (res_q),
        .i_raddr_a (ir_q[10:8]),
        .i_raddr_b (ir_q[7:5]),
        .o_rdata_a (w_rs_val),
        .o_rdata_b (w_rt_val)
    );

    always_comb begin
        w_alu = '0;
        case (ir_q[1:0])
            FN_ADD:  w_alu = w_rs_val + w_rt_val;
            FN_SUB:  w_alu = w_rs_val - w_rt_val;
            FN_XOR:  w_alu = w_rs_val ^ w_rt_val;
            FN_ANDN: w_alu = w_rs_val & ~w_rt_val;
            default: w_alu = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        res_d    = res_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        halted_d = halted_q;
        err_d    = err_q;
        case (state_q)
            FETCH: begin
                if (imem_rdy) begin
                    ir_d    = imem_rdata;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                case (w_op)
                    OP_HALT: begin
                        halted_d = 1'b1;
                        state_d  = HALT;
                    end
                    OP_NOP: begin
                        pc_d    = w_pc_inc;
                        state_d = FETCH;
                    end
                    OP_ADDI: begin
                        res_d   = w_rs_val + w_imm_s;
                        state_d = WB;
                    end
                    OP_XORI: begin
                        res_d   = w_rs_val ^ w_imm_z;
                        state_d = WB;
                    end
                    OP_RTYPE: begin
                        res_d   = w_alu;
                        state_d = WB;
                    end
                    OP_ST, OP_LD: begin
                        addr_d  = w_rs_val + w_imm_s;
                        wdata_d = w_rt_val;
                        state_d = MEM;
                    end
                    OP_BEQZ: begin
                        pc_d    = (w_rs_val == '0) ? w_pc_br : w_pc_inc;
                        state_d = FETCH;
                    end
                    OP_BNEZ: begin
                        pc_d    = (w_rs_val != '0) ? w_pc_br : w_pc_inc;
                        state_d = FETCH;
                    end
                    default: begin
                        err_d    = 1'b1;
                        halted_d = 1'b1;
                        state_d  = HALT;
                    end
                endcase
            end
            MEM: begin
                if (dmem_rdy) begin
                    if (w_op == OP_LD) begin
                        res_d = dmem_rdata;
                    end
                    state_d = WB;
                end
            end
            WB: begin
                pc_d    = w_pc_inc;
                state_d = FETCH;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            res_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            res_q    <= res_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            halted_q <= halted_d;
            err_q    <= err_d;
        end
    end

    // Gating with rst drops a pending fetch the instant reset asserts.
    assign imem_req   = (state_q == FETCH) && !rst;
    assign imem_addr  = pc_q;
    assign dmem_req   = (state_q == MEM);
    assign dmem_we    = (state_q == MEM) && (w_op == OP_ST);
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign halted     = halted_q;
    assign err        = err_q;

`ifdef PERF_CNT_EN
    logic        w_retire;
    logic [31:0] cnt_q, cnt_d;

    assign w_retire = (state_q == WB) ||
                      ((state_q == EXEC) &&
                       ((w_op == OP_HALT) || (w_op == OP_NOP) ||
                        (w_op == OP_BEQZ) || (w_op == OP_BNEZ)));

    always_comb begin
        cnt_d = cnt_q + 32'(w_retire);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign retired_cnt = cnt_q;
`else
    assign retired_cnt = '0;
`endif

endmodule
`default_nettype wire
